io_lane_mux: RTL and testbench
==============================

# io_lane_mux

Parametrised multi-lane input concentrator that replaces the fixed, unhandshaked data1..data20 word ports at the processor top boundary. It accepts NCH independent WIDTH-bit lanes with valid/ready handshakes and arbitrates among them round-robin. Accepted words go into a shared DEPTH-entry first-word-fall-through FIFO, which drives a single tagged output stream to the processor's load/instruction port.

## Interface
- NCH, 4: number of input lanes, 2..16
- WIDTH, 32: lane data width
- DEPTH, 8: FIFO entries, power of two, ≥2
- CW, $clog2(NCH): lane-index width (derived)
- LW, $clog2(DEPTH)+1: level width (derived)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- lane_valid  in  NCH  per-lane word valid
- lane_data  in  NCH*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- lane_ready  out  NCH  one-hot or zero grant; word accepted when valid&ready
- out_valid  out  1  FIFO head valid
- out_data  out  WIDTH  FIFO head word
- out_ch  out  CW  source lane of head word
- out_ready  in  1  consumer accepts head
- level  out  LW  current occupancy, 0..DEPTH
- full  out  1  level==DEPTH
- empty  out  1  level==0

## Operation
- Arbiter: round-robin over lanes with lane_valid=1. Search starts at rr_ptr+1 mod NCH. At most one lane is granted per cycle.
- lane_ready[i] = grant[i] & (!full | pop). Ready is combinational from valid, full and out_ready.
- push = |(lane_valid & lane_ready). On push, {lane index, word} is written at wr_ptr, wr_ptr increments, and rr_ptr is set to the granted index.
- rr_ptr does not move without a push.
- pop = out_valid & out_ready. rd_ptr increments on pop.
- Pointers are log2(DEPTH) bits and wrap naturally. level tracks occupancy: +1 on push only, −1 on pop only, unchanged on both.
- Output is FWFT: out_valid = !empty. out_data and out_ch show the head entry.
- While out_valid=1 and out_ready=0, out_data and out_ch hold stable.
- Boundary conditions:
  - Full with pop in the same cycle: push permitted, level stays DEPTH.
  - Full without pop: lane_ready all zero.
  - Empty: pop impossible; a push makes out_valid=1 the next cycle (no bypass).
  - Lane dropping valid without acceptance: allowed; that lane is not granted.

## Timing
- Reset (reset=0 at a clk edge):
  - wr_ptr = rd_ptr = 0, level = 0, rr_ptr = NCH-1 (lane 0 has first priority).
  - Resulting outputs: out_valid=0, empty=1, full=0, lane_ready=0 while reset is asserted, out_data/out_ch = 0.
- Reset mid-operation: FIFO contents are discarded and occupancy is zero on the next cycle. Storage RAM need not be cleared, but out_data must read 0 while empty.
- Latency: a word accepted at edge n has out_valid=1 after edge n, i.e. visible in cycle n+1.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- IO_LANE_MUX_STATS_EN defined: adds input stat_sel (CW) and output stat_cnt (16).
  - Per-lane 16-bit counters increment on each accepted word from that lane and saturate at 16'hFFFF.
  - Counters clear on reset. stat_cnt = counter[stat_sel], combinational.
- Not defined: the stat ports and counters are absent. Datapath behaviour is identical either way.

## Structure
- Shared package io_pkg holds:
  - localparams for default NCH/WIDTH/DEPTH;
  - typedef lane_entry_t {ch, data};
  - the saturating counter max constant.
- One sub-module: rr_arbiter (NCH request in, one-hot grant out, update strobe, internal rr_ptr).
- The FIFO storage and pointers live in io_lane_mux.

## Test plan
- Single lane: lane 2 presents 32'h48060123 on an empty FIFO.
  - Required: lane_ready[2]=1 in the same cycle; next cycle out_valid=1, out_data=32'h48060123, out_ch=2, level=1.
- Fairness: all 4 lanes valid continuously, out_ready=1.
  - Required: grant order 0,1,2,3,0,1,… with one word per cycle and level steady at 1.
- Fill: lanes 0..3 valid, out_ready=0, DEPTH=8.
  - Required: after 8 accepts full=1, lane_ready=0, level=8. Holding out_ready=0 keeps the head word stable.
- Full with simultaneous pop: at full, out_ready=1 and lane 1 valid.
  - Required: push and pop in the same cycle, level stays 8, and order is preserved across the pointer wrap.
- Reset mid-stream: reset=0 for one edge with level=5.
  - Required: next cycle level=0, out_valid=0, out_data=0. The first post-reset grant goes to the lowest valid lane index.
- With IO_LANE_MUX_STATS_EN: 70000 accepts from lane 3.
  - Required: stat_cnt with stat_sel=3 reads 16'hFFFF; the other lanes read their exact counts.

Source files
------------

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared defaults, entry type and stat constants for io_lane_mux
package io_pkg;

    localparam int NCH_DEF   = 4;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 8;

    // Lane index width that covers the largest supported lane count (16)
    localparam int CH_W_DEF  = 4;

    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    // One FIFO entry at the default configuration: source lane plus word
    typedef struct packed {
        logic [CH_W_DEF-1:0]  ch;
        logic [WIDTH_DEF-1:0] data;
    } lane_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and update strobe
module rr_arbiter
    import io_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    localparam int CW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic           update,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  grant_idx
);

    logic [CW-1:0] rr_ptr;
    logic          found;
    int            idx;

    // Search from the lane after the last winner; first requester wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CW'(idx);
            end
        end
    end

    // Pointer only advances when the granted word is actually accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= CW'(NCH - 1);
        end else if (update) begin
            rr_ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/io_lane_mux.sv
// rtl/io_lane_mux.sv - multi-lane concentrator into a tagged FWFT FIFO (option: IO_LANE_MUX_STATS_EN)
module io_lane_mux
    import io_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW   = $clog2(NCH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     lane_valid,
    input  logic [NCH*WIDTH-1:0] lane_data,
    output logic [NCH-1:0]     lane_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [CW-1:0]      out_ch,
    input  logic               out_ready,
    output logic [LW-1:0]      level,
    output logic               full,
    output logic               empty
`ifdef IO_LANE_MUX_STATS_EN
    ,input  logic [CW-1:0]     stat_sel
    ,output logic [15:0]       stat_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [CW-1:0]    ch;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [NCH-1:0]  grant;
    logic [CW-1:0]   grant_idx;
    logic            can_accept;
    logic            push;
    logic            pop;
    logic [WIDTH-1:0] wdata;

    assign full       = (level == LW'(DEPTH));
    assign empty      = (level == '0);
    assign out_valid  = !empty;
    assign pop        = out_valid & out_ready;
    // A pop frees a slot this cycle, so a full FIFO can still take a word
    assign can_accept = reset & (!full | pop);
    assign lane_ready = grant & {NCH{can_accept}};
    assign push       = |(lane_valid & lane_ready);
    assign wdata      = lane_data[grant_idx*WIDTH +: WIDTH];
    // Head is forced to zero while empty so stale RAM never leaks out
    assign out_data   = empty ? '0 : mem[rd_ptr].data;
    assign out_ch     = empty ? '0 : mem[rd_ptr].ch;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (lane_valid),
        .update    (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Storage write; contents are not cleared, occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ch: grant_idx, data: wdata};
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves level unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef IO_LANE_MUX_STATS_EN
    logic [15:0] stat_q [NCH];

    // Per-lane accepted-word counters, saturating at the top value
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (lane_valid[i] && lane_ready[i] && stat_q[i] != STAT_MAX) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    // Selected counter readout; out-of-range selects read zero
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (stat_sel == CW'(i)) stat_cnt = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_io_lane_mux.sv
// tb/tb_io_lane_mux.sv - randomized and directed bench for io_lane_mux against a queue model
module tb_io_lane_mux;
    import io_pkg::*;

    localparam int NCH   = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 2;
    localparam int LW    = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       lane_valid;
    logic [NCH*WIDTH-1:0] lane_data;
    logic [NCH-1:0]       lane_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_ready;
    logic [LW-1:0]        level;
    logic                 full;
    logic                 empty;
`ifdef IO_LANE_MUX_STATS_EN
    logic [CW-1:0]        stat_sel;
    logic [15:0]          stat_cnt;
`endif

    io_lane_mux #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .lane_ready (lane_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_ready  (out_ready),
        .level      (level),
        .full       (full),
        .empty      (empty)
`ifdef IO_LANE_MUX_STATS_EN
        ,.stat_sel  (stat_sel)
        ,.stat_cnt  (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of accepted entries, last winner, per-lane counts
    lane_entry_t q[$];
    int          last_win = NCH - 1;
    int          cnt [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, compare every output against the model, then advance the model
    task automatic cyc(input logic rst_n, input logic [NCH-1:0] v,
                       input logic [NCH*WIDTH-1:0] d, input logic ordy);
        int g;
        int sz;
        bit m_pop;
        bit m_can;
        logic [NCH-1:0] exp_rdy;
        @(negedge clk);
        reset      = rst_n;
        lane_valid = v;
        lane_data  = d;
        out_ready  = ordy;
        #1;
        sz    = q.size();
        m_pop = (sz > 0) && ordy;
        m_can = (sz < DEPTH) || m_pop;
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
            if (g < 0 && v[(last_win + k) % NCH]) g = (last_win + k) % NCH;
        end
        exp_rdy = (rst_n && m_can && g >= 0) ? NCH'(1 << g) : '0;
        chk("lane_ready", 64'(lane_ready), 64'(exp_rdy));
        chk("out_valid",  64'(out_valid), 64'(sz > 0));
        chk("out_data",   64'(out_data),  (sz > 0) ? 64'(q[0].data) : 64'd0);
        chk("out_ch",     64'(out_ch),    (sz > 0) ? 64'(q[0].ch)   : 64'd0);
        chk("level",      64'(level),     64'(sz));
        chk("full",       64'(full),      64'(sz == DEPTH));
        chk("empty",      64'(empty),     64'(sz == 0));
        if (!rst_n) begin
            q.delete();
            last_win = NCH - 1;
            for (int i = 0; i < NCH; i++) cnt[i] = 0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (exp_rdy != '0) begin
                q.push_back('{ch: 4'(g), data: d[g*WIDTH +: WIDTH]});
                last_win = g;
                cnt[g]++;
            end
        end
    endtask

    function automatic logic [NCH*WIDTH-1:0] rnd_data();
        logic [NCH*WIDTH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*WIDTH +: WIDTH] = $urandom;
        return r;
    endfunction

    logic [NCH*WIDTH-1:0] dd;
    logic [WIDTH-1:0]     head;

    initial begin
        reset      = 1'b0;
        lane_valid = '0;
        lane_data  = '0;
        out_ready  = 1'b0;
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
`ifdef IO_LANE_MUX_STATS_EN
        stat_sel = '0;
`endif

        // Reset state
        cyc(0, '0, '0, 0);
        cyc(0, 4'b1111, rnd_data(), 1);
        chk("rst_ready_zero", 64'(lane_ready), 64'd0);
        cyc(1, '0, '0, 0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);

        // Single lane 2 word on an empty FIFO
        dd = '0;
        dd[2*WIDTH +: WIDTH] = 32'h48060123;
        cyc(1, 4'b0100, dd, 0);
        chk("single_ready", 64'(lane_ready), 64'b0100);
        cyc(1, '0, '0, 0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data",  64'(out_data),  64'h48060123);
        chk("single_ch",    64'(out_ch),    64'd2);
        chk("single_level", 64'(level),     64'd1);
        cyc(1, '0, '0, 1);

        // Fairness: all lanes valid, consumer always ready
        cyc(0, '0, '0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 4'b1111, rnd_data(), 1);
            chk("fair_grant", 64'(lane_ready), 64'(1 << (i % NCH)));
            if (i > 0) chk("fair_level", 64'(level), 64'd1);
        end

        // Fill with consumer stalled, then hold head stable
        cyc(0, '0, '0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(1, 4'b1111, rnd_data(), 0);
        cyc(1, 4'b1111, rnd_data(), 0);
        chk("fill_full",  64'(full),       64'd1);
        chk("fill_ready", 64'(lane_ready), 64'd0);
        chk("fill_level", 64'(level),      64'd8);
        head = out_data;
        for (int i = 0; i < 3; i++) cyc(1, 4'b1111, rnd_data(), 0);
        chk("fill_head_hold", 64'(out_data), 64'(head));

        // Full with simultaneous pop, running across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1, 4'b0010, rnd_data(), 1);
            chk("fullpop_ready", 64'(lane_ready), 64'b0010);
        end
        chk("fullpop_level", 64'(level), 64'd8);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, '0, '0, 1);

        // Reset mid-stream at level 5
        cyc(0, '0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 4'b1111, rnd_data(), 0);
        cyc(0, 4'b1111, rnd_data(), 0);
        cyc(1, 4'b1010, rnd_data(), 0);
        chk("midrst_level", 64'(level),      64'd0);
        chk("midrst_valid", 64'(out_valid),  64'd0);
        chk("midrst_data",  64'(out_data),   64'd0);
        chk("midrst_grant", 64'(lane_ready), 64'b0010);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0), NCH'($urandom), rnd_data(),
                ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 9) > 2) : 1'b0);
        end

`ifdef IO_LANE_MUX_STATS_EN
        // Saturating counters: small counts on lanes 0/1, many accepts on lane 3
        cyc(0, '0, '0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 4'b0001, rnd_data(), 1);
        for (int i = 0; i < 7; i++) cyc(1, 4'b0010, rnd_data(), 1);
        for (int i = 0; i < 70000; i++) cyc(1, 4'b1000, rnd_data(), 1);
        cyc(1, '0, '0, 1);
        for (int i = 0; i < NCH; i++) begin
            stat_sel = CW'(i);
            #1;
            chk("stat_cnt", 64'(stat_cnt), (cnt[i] > 65535) ? 64'hFFFF : 64'(cnt[i]));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
